// File: rtl/vec_add_sub_ctrl.sv
// Element-wise vector add/subtract sequencer: reads A/B words, writes lane-wise results to R.
// Optional sticky signed-overflow flag (port ovf) when VEC_ADD_SUB_CTRL_OVF_EN is defined.

module single_add_sub #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    input  logic            sub_i,
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
    output logic            ovf_o,
`endif
    output logic [BITS-1:0] y_o
);
    logic [BITS-1:0] b_eff;

    // Subtraction as a + ~b + 1 so overflow can be judged on the effective operand sign.
    assign b_eff = sub_i ? ~b_i : b_i;
    assign y_o   = a_i + b_eff + BITS'(sub_i);

`ifdef VEC_ADD_SUB_CTRL_OVF_EN
    assign ovf_o = (a_i[BITS-1] == b_eff[BITS-1]) && (y_o[BITS-1] != a_i[BITS-1]);
`endif
endmodule

module vec_add_sub_ctrl #(
    parameter int BITS   = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [ADDR_W:0]       len,
    input  logic                  abort,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [LANES*BITS-1:0] a_data,
    input  logic [LANES*BITS-1:0] b_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [LANES*BITS-1:0] wr_data,
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
    output logic                  ovf,
`endif
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W:0]       cnt_q, cnt_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic                  sub_q, sub_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [LANES*BITS-1:0] wr_data_q, wr_data_d;
    logic [LANES*BITS-1:0] lane_sum;
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
    logic [LANES-1:0]      lane_ovf;
    logic                  ovf_q, ovf_d;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        single_add_sub #(.BITS(BITS)) u_slice (
            .a_i   (a_data[g*BITS +: BITS]),
            .b_i   (b_data[g*BITS +: BITS]),
            .sub_i (sub_q),
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
            .ovf_o (lane_ovf[g]),
`endif
            .y_o   (lane_sum[g*BITS +: BITS])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sub_d      = sub_q;
        s1_valid_d = 1'b0;
        s1_addr_d  = s1_addr_q;
        wr_en_d    = s1_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
        ovf_d      = ovf_q;
`endif

        if (s1_valid_q) begin
            wr_addr_d = s1_addr_q;
            wr_data_d = lane_sum;
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
            ovf_d     = ovf_q | (|lane_ovf);
`endif
        end

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    sub_d   = sub;
                    len_d   = len;
                    cnt_d   = '0;
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                s1_valid_d = 1'b1;
                s1_addr_d  = cnt_q[ADDR_W-1:0];
                // Full-width compare so len = 2^ADDR_W terminates without wrapping.
                if ((cnt_q + (ADDR_W+1)'(1)) == len_q) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                end
            end
            DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort squashes everything in flight; the word in stage 1 never counts as written.
        if (abort && (state_q == RUN || state_q == DRAIN)) begin
            state_d    = IDLE;
            s1_valid_d = 1'b0;
            wr_en_d    = 1'b0;
            wr_addr_d  = wr_addr_q;
            wr_data_d  = wr_data_q;
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
            ovf_d      = ovf_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            sub_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sub_q      <= sub_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign rd_en   = (state_q == RUN);
    assign rd_addr = cnt_q[ADDR_W-1:0];
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
    assign ovf     = ovf_q;
`endif
endmodule

// File: tb/tb_vec_add_sub_ctrl.sv
// Directed table-driven bench for vec_add_sub_ctrl; covers VEC_ADD_SUB_CTRL_OVF_EN when defined.

module tb_vec_add_sub_ctrl;
    localparam int BITS   = 8;
    localparam int LANES  = 4;
    localparam int ADDR_W = 8;
    localparam int W      = LANES * BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sub = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              abort = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      a_data = '0;
    logic [W-1:0]      b_data = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_data;
    logic              busy;
    logic              done;
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
    logic              ovf;
`endif

    vec_add_sub_ctrl #(.BITS(BITS), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .len     (len),
        .abort   (abort),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .a_data  (a_data),
        .b_data  (b_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
        .ovf     (ovf),
`endif
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Operand RAMs: one-cycle read latency.
    logic [W-1:0] mem_a [256];
    logic [W-1:0] mem_b [256];
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[rd_addr];
            b_data <= mem_b[rd_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = a;
            mem_b[i] = b;
        end
    endtask

    // Issue a start, then check every cycle T+rel against the fixed-latency timeline.
    task automatic run_op(input int n, input bit s, input logic [W-1:0] expw, input bit expo,
                          input int abort_rel, input int st_from, input int st_to, input int extra);
        int done_rel;
        int last_rel;
        bit active, e_rd, e_wr, e_done, e_busy;
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        len   = n[ADDR_W:0];
        @(negedge clk);
        start = 1'b0;
        sub   = ~s;
        len   = '1;
        done_rel = (n == 0) ? 1 : 3 + n;
        last_rel = (abort_rel >= 0) ? abort_rel + 2 + extra : done_rel + extra;
        for (int rel = 1; rel <= last_rel; rel++) begin
            if (rel > 1) @(negedge clk);
            active = (abort_rel < 0) || (rel <= abort_rel);
            e_rd   = active && rel <= n;
            e_wr   = active && rel >= 3 && rel <= n + 2;
            e_done = (abort_rel < 0) && rel == done_rel;
            e_busy = active && n != 0 && rel < done_rel;
            chk($sformatf("status[len=%0d rel=%0d]", n, rel),
                {60'd0, busy, done, rd_en, wr_en}, {60'd0, e_busy, e_done, e_rd, e_wr});
            if (e_rd) chk($sformatf("rd_addr[rel=%0d]", rel), 64'(rd_addr), 64'(rel - 1));
            if (e_wr) chk($sformatf("wr[rel=%0d]", rel), {24'd0, wr_addr, wr_data},
                          {24'd0, ADDR_W'(rel - 3), expw});
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
            if (rel == 1) chk("ovf_clear_on_start", 64'(ovf), 64'd0);
            if (e_done)   chk($sformatf("ovf_at_done[len=%0d]", n), 64'(ovf), 64'(expo));
`else
            if (expo && e_done) tests = tests + 0;
`endif
            abort = (rel == abort_rel);
            start = (rel >= st_from && rel <= st_to);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    typedef struct {
        int           n;
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           exp_ovf;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{3,   1'b0, 32'h04030201, 32'h01010101, 32'h05040302, 1'b0};
        vt[1] = '{1,   1'b1, 32'h00000000, 32'h01010101, 32'hFFFFFFFF, 1'b0};
        vt[2] = '{2,   1'b0, 32'h007F0000, 32'h00010000, 32'h00800000, 1'b1};
        vt[3] = '{0,   1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        vt[4] = '{4,   1'b1, 32'h10203040, 32'h01020304, 32'h0F1E2D3C, 1'b0};
        vt[5] = '{1,   1'b1, 32'h00000080, 32'h00000001, 32'h0000007F, 1'b1};
        vt[6] = '{2,   1'b0, 32'hFFFFFFFF, 32'h01010101, 32'h00000000, 1'b0};
        vt[7] = '{256, 1'b0, 32'h01010101, 32'h02020202, 32'h03030303, 1'b0};

        fill('0, '0);
        #1;
        chk("reset_outputs", {12'd0, rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            fill(vt[i].a, vt[i].b);
            run_op(vt[i].n, vt[i].s, vt[i].exp, vt[i].exp_ovf, -1, 0, -1, 2);
        end

        // start held through the busy window and the DONE cycle must not launch a second run.
        fill(32'h04030201, 32'h01010101);
        run_op(4, 1'b0, 32'h05040302, 1'b0, -1, 2, 7, 4);

        // Abort in T+3 of a len=8 run: only word 0 lands, then silence.
        run_op(8, 1'b0, 32'h05040302, 1'b0, 3, 0, -1, 4);

        // start coincident with abort in IDLE is ignored.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        len   = 9'd3;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("start_with_abort[c=%0d]", c), {60'd0, busy, done, rd_en, wr_en}, 64'd0);
            @(negedge clk);
        end

        // Asynchronous reset mid-run, then a clean len=2 run.
        fill(32'h01010101, 32'h01010101);
        start = 1'b1;
        sub   = 1'b0;
        len   = 9'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {12'd0, rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data}, 64'd0);
        @(negedge clk);
        chk("reset_held_outputs", {12'd0, rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data}, 64'd0);
`ifdef VEC_ADD_SUB_CTRL_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2, 1'b0, 32'h02020202, 1'b0, -1, 0, -1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
